efx_sync_fifo: RTL and testbench

// - Parametrised single-clock FIFO with a behavioural simple-dual-port block-RAM core.
// - Generalises the 5K RAM primitive: arbitrary width/depth, optional output register, programmable almost-flags, overflow/underflow reporting.
// - Sits between soft-logic producers and consumers in Efinix-mapped designs; also the sim model for inferred FIFOs.

---
 rtl/efx_pkg.sv | 20 ++
 rtl/efx_sdp_ram.sv | 41 ++++
 rtl/efx_sync_fifo.sv | 101 ++++++++++
 tb/tb_efx_sync_fifo.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/efx_pkg.sv
// efx_pkg: shared types and helpers for the Efinix-style RAM/FIFO models.
package efx_pkg;

    typedef enum logic {
        READ_FIRST  = 1'b0,
        WRITE_FIRST = 1'b1
    } ram_mode_e;

    function automatic logic apply_pol(input logic s, input bit active_high);
        return active_high ? s : ~s;
    endfunction

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/efx_sdp_ram.sv
// efx_sdp_ram: simple-dual-port RAM with sync write, registered read and optional output register.
module efx_sdp_ram
    import efx_pkg::*;
#(
    parameter int        DATA_WIDTH = 20,
    parameter int        ADDR_WIDTH = 8,
    parameter int        OUTPUT_REG = 0,
    parameter ram_mode_e MODE       = READ_FIRST
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic                  oce,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rd_q, out_q;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read-first returns the pre-write word on a same-address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            out_q <= '0;
        end else begin
            if (re) rd_q <= (MODE == WRITE_FIRST && we && waddr == raddr) ? wdata : mem[raddr];
            if (oce) out_q <= rd_q;
        end
    end

    assign rdata = (OUTPUT_REG != 0) ? out_q : rd_q;

endmodule

// File: rtl/efx_sync_fifo.sv
// efx_sync_fifo: single-clock FIFO over efx_sdp_ram with registered flags,
// programmable almost-flags and overflow/underflow pulses.
module efx_sync_fifo
    import efx_pkg::*;
#(
    parameter int DATA_WIDTH   = 20,
    parameter int ADDR_WIDTH   = 8,
    parameter int OUTPUT_REG   = 0,
    parameter int AFULL_LEVEL  = (1 << ADDR_WIDTH) - 4,
    parameter int AEMPTY_LEVEL = 4,
    parameter int WE_POLARITY  = 1,
    parameter int RE_POLARITY  = 1
)(
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic                  WE,
    input  logic                  RE,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic                  RVALID,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  AFULL,
    output logic                  AEMPTY,
    output logic [ADDR_WIDTH:0]   COUNT,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);

    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] AF    = (ADDR_WIDTH+1)'(AFULL_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE    = (ADDR_WIDTH+1)'(AEMPTY_LEVEL);

    logic                we_a, re_a, wr_acc, rd_acc;
    logic [ADDR_WIDTH:0] wptr, rptr, count, count_nxt;
    logic                full_q, empty_q, afull_q, aempty_q, ovf_q, unf_q, v1, v2;

    assign we_a   = apply_pol(WE, WE_POLARITY != 0);
    assign re_a   = apply_pol(RE, RE_POLARITY != 0);
    assign rd_acc = re_a && !empty_q;
    // A pop on the same edge frees the slot, so a full FIFO still takes the write.
    assign wr_acc = we_a && (!full_q || rd_acc);

    assign count_nxt = (wr_acc && !rd_acc) ? count + 1'b1 :
                       (rd_acc && !wr_acc) ? count - 1'b1 : count;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            v1       <= 1'b0;
            v2       <= 1'b0;
        end else begin
            if (wr_acc) wptr <= wptr + 1'b1;
            if (rd_acc) rptr <= rptr + 1'b1;
            count    <= count_nxt;
            full_q   <= count_nxt == DEPTH;
            empty_q  <= count_nxt == '0;
            afull_q  <= count_nxt >= AF;
            aempty_q <= count_nxt <= AE;
            ovf_q    <= we_a && !wr_acc;
            unf_q    <= re_a && !rd_acc;
            v1       <= rd_acc;
            v2       <= v1;
        end
    end

    efx_sdp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .OUTPUT_REG (OUTPUT_REG),
        .MODE       (READ_FIRST)
    ) u_ram (
        .clk   (CLK),
        .rst_n (RSTN),
        .we    (wr_acc),
        .waddr (wptr[ADDR_WIDTH-1:0]),
        .wdata (WDATA),
        .re    (rd_acc),
        .raddr (rptr[ADDR_WIDTH-1:0]),
        .oce   (v1),
        .rdata (RDATA)
    );

    assign RVALID    = (OUTPUT_REG != 0) ? v2 : v1;
    assign FULL      = full_q;
    assign EMPTY     = empty_q;
    assign AFULL     = afull_q;
    assign AEMPTY    = aempty_q;
    assign COUNT     = count;
    assign OVERFLOW  = ovf_q;
    assign UNDERFLOW = unf_q;

endmodule

// File: tb/tb_efx_sync_fifo.sv
// tb_efx_sync_fifo: two FIFOs (OUTPUT_REG 0 and 1) on shared stimulus, checked
// against a queue-based model of the FIFO rules.
module tb_efx_sync_fifo;

    logic        CLK = 1'b0, RSTN = 1'b0, WE = 1'b0, RE = 1'b0;
    logic [19:0] WDATA = '0;
    logic [19:0] rdata0, rdata1;
    logic        rvalid0, full0, empty0, afull0, aempty0, ovf0, unf0;
    logic        rvalid1, full1, empty1, afull1, aempty1, ovf1, unf1;
    logic [3:0]  count0, count1;

    int n_cmp = 0, n_err = 0;

    logic [19:0] q[$];
    bit          m_rv0, m_rv1, m_ovf, m_unf;
    logic [19:0] m_rd0, m_rd1;

    always #5 CLK = ~CLK;

    efx_sync_fifo #(.DATA_WIDTH(20), .ADDR_WIDTH(3), .OUTPUT_REG(0)) u0 (
        .CLK(CLK), .RSTN(RSTN), .WDATA(WDATA), .WE(WE), .RE(RE),
        .RDATA(rdata0), .RVALID(rvalid0), .FULL(full0), .EMPTY(empty0),
        .AFULL(afull0), .AEMPTY(aempty0), .COUNT(count0),
        .OVERFLOW(ovf0), .UNDERFLOW(unf0));

    efx_sync_fifo #(.DATA_WIDTH(20), .ADDR_WIDTH(3), .OUTPUT_REG(1)) u1 (
        .CLK(CLK), .RSTN(RSTN), .WDATA(WDATA), .WE(WE), .RE(RE),
        .RDATA(rdata1), .RVALID(rvalid1), .FULL(full1), .EMPTY(empty1),
        .AFULL(afull1), .AEMPTY(aempty1), .COUNT(count1),
        .OVERFLOW(ovf1), .UNDERFLOW(unf1));

    task automatic model_reset();
        q.delete();
        m_rv0 = 0; m_rv1 = 0; m_ovf = 0; m_unf = 0;
        m_rd0 = '0; m_rd1 = '0;
    endtask

    // Drive one cycle, advance the model across the edge, return 1 unit after it.
    task automatic cyc(input bit w, input bit r, input logic [19:0] d);
        bit rok, wok;
        WE = w; RE = r; WDATA = d;
        @(posedge CLK);
        rok   = r && q.size() != 0;
        wok   = w && (q.size() < 8 || rok);
        m_ovf = w && !wok;
        m_unf = r && !rok;
        m_rv1 = m_rv0;
        if (m_rv0) m_rd1 = m_rd0;
        m_rv0 = rok;
        if (rok) m_rd0 = q.pop_front();
        if (wok) q.push_back(d);
        #1;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if ({count0, empty0, aempty0, full0, afull0, rvalid0, ovf0, unf0} !== {4'd0, 7'b1100000}) begin
            n_err++;
            $display("FAIL reset_flags got=%b exp=%b", {count0, empty0, aempty0, full0, afull0, rvalid0, ovf0, unf0}, {4'd0, 7'b1100000});
        end
        n_cmp++;
        if ({rdata0, rdata1, rvalid1} !== 41'd0) begin
            n_err++;
            $display("FAIL reset_data got=%h/%h/%b exp=0/0/0", rdata0, rdata1, rvalid1);
        end
        RSTN = 1'b1;
        model_reset();
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            cyc(1, 0, 20'(i));
            n_cmp++;
            if ({count0, full0, afull0, aempty0, empty0} !== {4'(i), i == 8, i >= 4, i <= 4, 1'b0}) begin
                n_err++;
                $display("FAIL fill_%0d got cnt=%0d f=%b af=%b ae=%b e=%b exp cnt=%0d f=%b af=%b ae=%b",
                         i, count0, full0, afull0, aempty0, empty0, i, i == 8, i >= 4, i <= 4);
            end
        end
    endtask

    task automatic test_full_rw();
        cyc(1, 1, 20'h55);
        n_cmp++;
        if ({count0, full0, ovf0, rvalid0, rdata0} !== {4'd8, 1'b1, 1'b0, 1'b1, 20'h1}) begin
            n_err++;
            $display("FAIL full_rw got cnt=%0d f=%b ovf=%b rv=%b rd=%h exp 8 1 0 1 00001", count0, full0, ovf0, rvalid0, rdata0);
        end
        cyc(1, 0, 20'h77);
        n_cmp++;
        if ({count0, full0, ovf0, ovf1, rvalid0, rdata0} !== {4'd8, 1'b1, 1'b1, 1'b1, 1'b0, 20'h1}) begin
            n_err++;
            $display("FAIL full_ovf got cnt=%0d f=%b ovf=%b/%b rv=%b rd=%h exp 8 1 1/1 0 00001", count0, full0, ovf0, ovf1, rvalid0, rdata0);
        end
        n_cmp++;
        if ({rvalid1, rdata1} !== {1'b1, 20'h1}) begin
            n_err++;
            $display("FAIL full_oreg got rv=%b rd=%h exp 1 00001", rvalid1, rdata1);
        end
        cyc(0, 0, 0);
        n_cmp++;
        if ({ovf0, count0} !== {1'b0, 4'd8}) begin
            n_err++;
            $display("FAIL ovf_pulse got ovf=%b cnt=%0d exp 0 8", ovf0, count0);
        end
    endtask

    task automatic test_drain();
        logic [19:0] exp_d [8];
        exp_d = '{20'h2, 20'h3, 20'h4, 20'h5, 20'h6, 20'h7, 20'h8, 20'h55};
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, 0);
            n_cmp++;
            if ({rvalid0, rdata0, count0} !== {1'b1, exp_d[i], 4'(7 - i)}) begin
                n_err++;
                $display("FAIL drain_%0d got rv=%b rd=%h cnt=%0d exp 1 %h %0d", i, rvalid0, rdata0, count0, exp_d[i], 7 - i);
            end
        end
        n_cmp++;
        if ({empty0, full0, afull0, aempty0} !== 4'b1001) begin
            n_err++;
            $display("FAIL drain_empty got e=%b f=%b af=%b ae=%b exp 1 0 0 1", empty0, full0, afull0, aempty0);
        end
        cyc(0, 0, 0);
        n_cmp++;
        if ({rvalid0, rvalid1, rdata1, rdata0} !== {2'b01, 20'h55, 20'h55}) begin
            n_err++;
            $display("FAIL drain_tail got rv0=%b rv1=%b rd1=%h rd0=%h exp 0 1 00055 00055", rvalid0, rvalid1, rdata1, rdata0);
        end
    endtask

    task automatic test_empty_rw();
        cyc(1, 1, 20'h33);
        n_cmp++;
        if ({unf0, count0, rvalid0, empty0} !== {1'b1, 4'd1, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL empty_rw got unf=%b cnt=%0d rv=%b e=%b exp 1 1 0 0", unf0, count0, rvalid0, empty0);
        end
        cyc(0, 1, 0);
        n_cmp++;
        if ({rvalid0, rdata0, unf0, empty0} !== {1'b1, 20'h33, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL empty_read got rv=%b rd=%h unf=%b e=%b exp 1 00033 0 1", rvalid0, rdata0, unf0, empty0);
        end
        cyc(0, 1, 0);
        n_cmp++;
        if ({unf0, unf1, rvalid0} !== 3'b110) begin
            n_err++;
            $display("FAIL underflow got unf=%b/%b rv=%b exp 1/1 0", unf0, unf1, rvalid0);
        end
        cyc(0, 0, 0);
    endtask

    task automatic test_outreg();
        cyc(1, 0, 20'hABCDE);
        cyc(0, 1, 0);
        n_cmp++;
        if ({rvalid1, rvalid0, rdata0} !== {2'b01, 20'hABCDE}) begin
            n_err++;
            $display("FAIL oreg_lat1 got rv1=%b rv0=%b rd0=%h exp 0 1 abcde", rvalid1, rvalid0, rdata0);
        end
        cyc(0, 0, 0);
        n_cmp++;
        if ({rvalid1, rdata1} !== {1'b1, 20'hABCDE}) begin
            n_err++;
            $display("FAIL oreg_lat2 got rv=%b rd=%h exp 1 abcde", rvalid1, rdata1);
        end
        cyc(0, 0, 0);
        n_cmp++;
        if ({rvalid1, rdata1} !== {1'b0, 20'hABCDE}) begin
            n_err++;
            $display("FAIL oreg_hold got rv=%b rd=%h exp 0 abcde", rvalid1, rdata1);
        end
    endtask

    task automatic test_wrap();
        logic [19:0] d, prev;
        prev = 20'hABCDE;
        for (int i = 0; i < 20; i++) begin
            d = 20'($urandom);
            cyc(1, 0, d);
            n_cmp++;
            if (i > 0 && {rvalid1, rdata1} !== {1'b1, prev}) begin
                n_err++;
                $display("FAIL wrap_oreg_%0d got rv=%b rd=%h exp 1 %h", i, rvalid1, rdata1, prev);
            end
            cyc(0, 1, 0);
            n_cmp++;
            if ({rvalid0, rdata0, count0} !== {1'b1, d, 4'd0}) begin
                n_err++;
                $display("FAIL wrap_%0d got rv=%b rd=%h cnt=%0d exp 1 %h 0", i, rvalid0, rdata0, count0, d);
            end
            prev = d;
        end
        cyc(0, 0, 0);
    endtask

    task automatic test_random();
        logic [19:0] got, exp;
        int sz;
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 99) < (i % 100 < 50 ? 75 : 25),
                $urandom_range(0, 99) < (i % 100 < 50 ? 30 : 70), 20'($urandom));
            sz  = q.size();
            got = {count0, full0, empty0, afull0, aempty0, ovf0, unf0, rvalid0, rvalid1, count1[2:0]};
            exp = {4'(sz), sz == 8, sz == 0, sz >= 4, sz <= 4, m_ovf, m_unf, m_rv0, m_rv1, 3'(sz)};
            n_cmp++;
            if (got !== exp || count1 !== count0) begin
                n_err++;
                $display("FAIL rnd_ctl_%0d got=%h exp=%h cnt1=%0d", i, got, exp, count1);
            end
            n_cmp++;
            if ({rdata0, rdata1} !== {m_rd0, m_rd1}) begin
                n_err++;
                $display("FAIL rnd_data_%0d got=%h/%h exp=%h/%h", i, rdata0, rdata1, m_rd0, m_rd1);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) cyc(1, 0, 20'(i + 'h100));
        cyc(1, 1, 20'h200);
        cyc(0, 1, 0);
        RSTN = 1'b0;
        #1;
        n_cmp++;
        if ({count0, empty0, full0, rvalid0, rvalid1, rdata0, rdata1} !== {4'd0, 1'b1, 3'b000, 40'd0}) begin
            n_err++;
            $display("FAIL reset_mid got cnt=%0d e=%b f=%b rv=%b/%b rd=%h/%h exp 0 1 0 0/0 0/0",
                     count0, empty0, full0, rvalid0, rvalid1, rdata0, rdata1);
        end
        #2;
        RSTN = 1'b1;
        model_reset();
        cyc(0, 0, 0);
        n_cmp++;
        if ({rvalid0, rvalid1, empty0, count1} !== {3'b001, 4'd0}) begin
            n_err++;
            $display("FAIL reset_release got rv=%b/%b e=%b cnt1=%0d exp 0/0 1 0", rvalid0, rvalid1, empty0, count1);
        end
        cyc(1, 0, 20'h9);
        cyc(0, 1, 0);
        n_cmp++;
        if ({rvalid0, rdata0} !== {1'b1, 20'h9}) begin
            n_err++;
            $display("FAIL reset_resume got rv=%b rd=%h exp 1 00009", rvalid0, rdata0);
        end
        cyc(0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_rw();
        test_drain();
        test_empty_rw();
        test_outreg();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded time budget");
        $fatal(1);
    end

endmodule
